// File: rtl/matrix_host_loader.sv
// Host-side loader for the matrix coprocessor: unpacks a 32-bit word stream
// into instruction/matrix buses, runs one operation, and streams the result back.

module matrix_host_loader_lane #(
  parameter int E = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  word_idx,
  input  logic        wr_a,
  input  logic        wr_b,
  input  logic        clr,
  input  logic        cap,
  input  logic        res_clr,
  input  logic [31:0] cmd_data,
  input  logic [7:0]  res_in,
  output logic        hit,
  output logic [7:0]  m1,
  output logic [7:0]  m2,
  output logic [7:0]  res
);
  localparam logic [2:0] WORD = 3'(E / 4);
  localparam int         J    = E % 4;

  logic [7:0] m1_q, m1_d, m2_q, m2_d, res_q, res_d;
  logic [7:0] byte_in;

  assign hit     = (word_idx == WORD);
  assign byte_in = cmd_data[8*J +: 8];

  always_comb begin
    m1_d  = m1_q;
    m2_d  = m2_q;
    res_d = res_q;
    if (clr) begin
      m1_d = '0;
      m2_d = '0;
    end else begin
      if (wr_a && hit) m1_d = byte_in;
      if (wr_b && hit) m2_d = byte_in;
    end
    if (cap)          res_d = res_in;
    else if (res_clr) res_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1_q  <= '0;
      m2_q  <= '0;
      res_q <= '0;
    end else begin
      m1_q  <= m1_d;
      m2_q  <= m2_d;
      res_q <= res_d;
    end
  end

  assign m1  = m1_q;
  assign m2  = m2_q;
  assign res = res_q;
endmodule

module matrix_host_loader #(
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [31:0]  cmd_data,
  output logic [5:0]   instruction,
  output logic [199:0] matrix1,
  output logic [199:0] matrix2,
  output logic         start,
  input  logic [2:0]   cu_state,
  input  logic         cu_ready,
  input  logic [199:0] matrix_result,
  input  logic         overflow,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_data,
  output logic         res_last,
  output logic         res_ovf,
  output logic         timeout_err,
  output logic         busy
);
  localparam int          NUM_ELEM = 25;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HDR, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_UNLOAD
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [5:0]  instr_q, instr_d;
  logic        ovf_q, ovf_d, terr_q, terr_d;
  logic        xfer, last_word, clr, wr_a, wr_b, cap, res_clr;

  logic [NUM_ELEM-1:0]       hit;
  logic [NUM_ELEM-1:0][7:0]  m1_l, m2_l, res_l;
  logic [31:0]               res_word;

  // One lane per matrix element; word_idx selects the lanes covered by the
  // current load word or the current unload word.
  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_lane
    matrix_host_loader_lane #(.E(g)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .word_idx (wcnt_q),
      .wr_a     (wr_a),
      .wr_b     (wr_b),
      .clr      (clr),
      .cap      (cap),
      .res_clr  (res_clr),
      .cmd_data (cmd_data),
      .res_in   (matrix_result[199-8*g -: 8]),
      .hit      (hit[g]),
      .m1       (m1_l[g]),
      .m2       (m2_l[g]),
      .res      (res_l[g])
    );
    assign matrix1[199-8*g -: 8] = m1_l[g];
    assign matrix2[199-8*g -: 8] = m2_l[g];
  end

  assign cmd_ready = (state_q == S_HDR) || (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign xfer      = cmd_valid && cmd_ready;
  assign last_word = (wcnt_q == 3'd6);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    instr_d = instr_q;
    ovf_d   = ovf_q;
    terr_d  = terr_q;
    clr     = 1'b0;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    cap     = 1'b0;
    res_clr = 1'b0;
    case (state_q)
      S_HDR: if (xfer) begin
        instr_d = cmd_data[5:0];
        clr     = 1'b1;
        ovf_d   = 1'b0;
        terr_d  = 1'b0;
        wcnt_d  = '0;
        state_d = S_LOAD_A;
      end
      S_LOAD_A: if (xfer) begin
        wr_a = 1'b1;
        if (last_word) begin
          wcnt_d  = '0;
          state_d = S_LOAD_B;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      S_LOAD_B: if (xfer) begin
        wr_b = 1'b1;
        if (last_word) begin
          wcnt_d  = '0;
          tcnt_d  = '0;
          state_d = S_START;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      S_START: begin
        tcnt_d = tcnt_q + 16'd1;
        if (tcnt_q == TMO_LAST) begin
          terr_d  = 1'b1;
          res_clr = 1'b1;
          wcnt_d  = '0;
          state_d = S_UNLOAD;
        end else if (cu_state != 3'b000) begin
          // start is held until the divided-clock control unit has left IDLE
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + 16'd1;
        if (cu_ready) begin
          // capture beats a coincident terminal count
          cap     = 1'b1;
          ovf_d   = overflow;
          wcnt_d  = '0;
          state_d = S_UNLOAD;
        end else if (tcnt_q == TMO_LAST) begin
          terr_d  = 1'b1;
          res_clr = 1'b1;
          wcnt_d  = '0;
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD: if (res_ready) begin
        if (last_word) begin
          wcnt_d  = '0;
          state_d = S_HDR;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HDR;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      instr_q <= '0;
      ovf_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      instr_q <= instr_d;
      ovf_q   <= ovf_d;
      terr_q  <= terr_d;
    end
  end

  // Unload word k gathers elements 4k..4k+3; elements past 24 read as zero.
  always_comb begin
    res_word = '0;
    for (int e = 0; e < NUM_ELEM; e++) begin
      if (hit[e]) res_word[8*(e%4) +: 8] = res_l[e];
    end
  end

  assign instruction = instr_q;
  assign start       = (state_q == S_START);
  assign res_valid   = (state_q == S_UNLOAD);
  assign res_last    = (state_q == S_UNLOAD) && last_word;
  assign res_data    = (state_q == S_UNLOAD) ? res_word : 32'h0;
  assign res_ovf     = ovf_q;
  assign timeout_err = terr_q;
  assign busy        = (state_q != S_HDR);
endmodule
